// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants and frame FSM state type for the PS/2 RX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

endpackage

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ============================================================================
// Module      : ps2_clk_filter
// Description : 2-flop synchronisers for PS/2 clock/data plus clock debounce;
//               emits the filtered clock and a one-cycle falling-edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic fclk_o,
    output logic fall_o,
    output logic dat_o
);

    localparam int             CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          fclk_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            fclk_q     <= 1'b1;
            fall_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            fall_q     <= 1'b0;
            // Any sample matching the current level restarts the run count.
            if (clk_sync_q[1] == fclk_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                fclk_q <= ~fclk_q;
                fall_q <= fclk_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign fclk_o = fclk_q;
    assign fall_o = fall_q;
    assign dat_o  = dat_sync_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard receiver presenting the currently held scan code
//               as a registered level, with parity/stop/timeout checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keyboard_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic fclk;
    logic fall;
    logic dat;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .fclk_o    (fclk),
        .fall_o    (fall),
        .dat_o     (dat)
    );

    frame_state_e  state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          ext_q;
    logic          brk_q;
    logic [7:0]    kd_q;
    logic          byte_valid_q;
    logic          frame_err_q;

    // The extended prefix is tracked for completeness only; it never alters the code.
    logic unused_ok;
    assign unused_ok = ^{ext_q, fclk};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            kd_q         <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!dat) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= dat;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if ((^{shift_q, par_q}) && dat) begin
                            byte_valid_q <= 1'b1;
                            if (shift_q == PS2_EXT) begin
                                ext_q <= 1'b1;
                            end else if (shift_q == PS2_BRK) begin
                                brk_q <= 1'b1;
                            end else begin
                                if (!brk_q) begin
                                    kd_q <= shift_q;
                                end else if (shift_q == kd_q) begin
                                    kd_q <= 8'h00;
                                end
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_q       <= 1'b0;
                            brk_q       <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (to_cnt_q == TO_LAST) begin
                    state_q     <= IDLE;
                    to_cnt_q    <= '0;
                    frame_err_q <= 1'b1;
                    ext_q       <= 1'b0;
                    brk_q       <= 1'b0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign keyboard_data = kd_q;
    assign byte_valid    = byte_valid_q;
    assign frame_err     = frame_err_q;

endmodule

`default_nettype wire
